shift_fifo_v2: RTL and testbench
================================

Name: shift_fifo_v2

Overview:
- Parametrised successor to the team's shift-register FIFO. Stores up to DEPTH words of WIDTH bits in a shift register and presents the oldest word first-word-fall-through.
- Adds true simultaneous read/write, a full-range occupancy count, almost-full/almost-empty flags, a synchronous flush and sticky overflow/underflow error flags.
- Sits between pixel/line producers and consumers in the same datapath as the existing FIFOs; for small DEPTH it replaces them where a BRAM FIFO is overkill.

Parameters:
- WIDTH, 10, data word width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2).
- AFULL_LVL, DEPTH-1, almost_full asserts when count >= AFULL_LVL (1..DEPTH).
- AEMPTY_LVL, 1, almost_empty asserts when count <= AEMPTY_LVL (0..DEPTH-1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rst  in  1  synchronous flush, active-high; same effect as reset on state.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LVL.
- rd_en  in  1  read request (pops the presented word).
- rd_data  out  WIDTH  oldest stored word, valid while !empty.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst_n low, asynchronous) and flush (rst high at the edge):
  - count=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0, almost_empty=1, almost_full=0, rd_data='0.
  - Storage contents are not reset.
- Acceptance:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
  - Both are evaluated on pre-edge state.
  - A write while full is dropped, and storage is unchanged.
- Storage: on wr_acc, sreg[0] <= wr_data and sreg[i] <= sreg[i-1] for i=1..DEPTH-1. The newest word is at index 0.
- Count update:
  - wr_acc & !rd_acc: count+1.
  - rd_acc & !wr_acc: count-1.
  - both: count unchanged, but a shift still occurs.
  - neither: hold.
- Read port: rd_data = sreg[count-1] when count>0, else '0. It is combinational from registers with no extra register stage.
- Latency:
  - A word written at edge N appears on rd_data after edge N when the FIFO was empty, so empty falls one cycle after wr_en.
  - Read-to-next-word latency is 0 cycles: the next word is valid immediately after the popping edge.
- Simultaneous rd & wr:
  - At count=DEPTH: only the read is accepted (full blocks the write). count becomes DEPTH-1 and overflow is set.
  - At count=0: only the write is accepted (empty blocks the read). count becomes 1 and underflow is set.
  - At 0<count<DEPTH: both are accepted, and rd_data becomes the previously second-oldest word.
- Error flags:
  - overflow is set on wr_en & full. underflow is set on rd_en & empty.
  - Both are held until clr_err, rst or rst_n.
  - If clr_err and a new error event occur in the same cycle, the set wins.
- Flags and count are registered-derived only, with no combinational path from wr_en/rd_en to full/empty.
- Reset mid-operation: all queued words are discarded immediately. The first write after release behaves as a write into an empty FIFO.
- Elaboration checks (assertions at elaboration):
  - AFULL_LVL in 1..DEPTH.
  - AEMPTY_LVL < DEPTH.
  - DEPTH >= 2.

Decomposition:
- Shared package fifo_pkg holds:
  - the count-width function cnt_w(depth) = $clog2(depth+1);
  - a typedef for the error-flag struct {overflow, underflow}.
- One sub-module is natural: fifo_occ_ctrl. It contains the count register, the acceptance logic, the flag comparators and the sticky error flags. Storage and read mux stay in shift_fifo_v2.
- Ports are grouped onto the existing fifoWr_if.syncRx / fifoRd_if.syncTx modports at the wrapper level. The added signals (count, almost_*, errors, clr_err) are discrete ports.

Test Plan:
Parameters for all scenarios: WIDTH=8, DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1.
- Fill and drain: write 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then read 4.
  - During fill, count goes 1,2,3,4; almost_full rises at count=3 and full at count=4.
  - rd_data reads 0x11,0x22,0x33,0x44 in order; empty=1 afterwards.
- Overflow: at count=4, wr_en with 0x55.
  - Data is dropped, count stays 4, overflow=1.
  - After 4 reads no 0x55 appears.
  - Pulsing clr_err returns overflow to 0.
- Simultaneous rd/wr at count=2 holding 0xA0,0xA1: rd_en=wr_en=1 with 0xA2.
  - count stays 2 and rd_data=0xA1.
  - Next reads return 0xA1 then 0xA2.
- Edge cases:
  - Empty plus rd&wr with 0x7E: count=1, rd_data=0x7E next cycle, underflow=1.
  - Full plus rd&wr: count=3, overflow=1.
- Reset:
  - Async rst_n pulse mid-cycle at count=3: count, empty and error flags go to 0/1/0 immediately, without waiting for clk.
  - Sync rst at count=2: count=0 after that edge, and a following write of 0x5A reads back 0x5A.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the shift-register FIFO family.
`default_nettype none

package fifo_pkg;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

`default_nettype wire

// File: rtl/fifo_occ_ctrl.sv
// Occupancy control: acceptance, count register, level flags and sticky errors.
`default_nettype none

module fifo_occ_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  parameter int CW         = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic          wr_acc,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output err_flags_t    err
);

  logic [CW-1:0] r_count;
  err_flags_t    r_err;
  logic          w_rd_acc;

  // Flags depend only on the count register, never on this cycle's requests.
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AFULL_LVL));
  assign almost_empty = (r_count <= CW'(AEMPTY_LVL));

  assign wr_acc   = wr_en & ~full;
  assign w_rd_acc = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (rst) begin
      r_count <= '0;
    end else begin
      case ({wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (rst) begin
      r_err <= '0;
    end else begin
      r_err.overflow  <= (r_err.overflow  & ~clr_err) | (wr_en & full);
      r_err.underflow <= (r_err.underflow & ~clr_err) | (rd_en & empty);
    end
  end

  assign count = r_count;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: rtl/shift_fifo_v2.sv
// First-word-fall-through FIFO built on a shift register; newest word at index 0.
`default_nettype none

module shift_fifo_v2
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("shift_fifo_v2: DEPTH must be >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_chk_afull
    $error("shift_fifo_v2: AFULL_LVL must be within 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_chk_aempty
    $error("shift_fifo_v2: AEMPTY_LVL must be within 0..DEPTH-1");
  end

  logic             w_wr_acc;
  err_flags_t       w_err;
  logic [WIDTH-1:0] r_sreg [DEPTH];

  fifo_occ_ctrl #(
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL),
    .CW         (CW)
  ) u_occ (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .wr_acc       (w_wr_acc),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err          (w_err)
  );

  assign overflow  = w_err.overflow;
  assign underflow = w_err.underflow;

  // Storage is deliberately left out of reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_sreg[0] <= wr_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_sreg[i] <= r_sreg[i-1];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CW'(i + 1)) begin
        rd_data = r_sreg[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_fifo_v2.sv
// Directed self-checking bench for shift_fifo_v2 (WIDTH=8, DEPTH=4).
`default_nettype none

module tb_shift_fifo_v2;

  logic       clk = 1'b0;
  logic       rst_n, rst, wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  shift_fifo_v2 #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
    .clk(clk), .rst_n(rst_n), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, observe at the following falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_errs", {overflow, underflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill
    step(1, 8'h11, 0, 0);
    check("fill1_count", 32'(count), 1);
    check("fill1_rd", 32'(rd_data), 32'h11);
    check("fill1_empty", 32'(empty), 0);
    step(1, 8'h22, 0, 0);
    check("fill2_count", 32'(count), 2);
    check("fill2_afull", 32'(almost_full), 0);
    step(1, 8'h33, 0, 0);
    check("fill3_count", 32'(count), 3);
    check("fill3_afull", 32'(almost_full), 1);
    check("fill3_full", 32'(full), 0);
    step(1, 8'h44, 0, 0);
    check("fill4_count", 32'(count), 4);
    check("fill4_full", 32'(full), 1);

    // Overflow: write while full is dropped
    step(1, 8'h55, 0, 0);
    check("ovf_count", 32'(count), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_rd", 32'(rd_data), 32'h11);

    // Drain
    step(0, 0, 1, 0);
    check("drain1_rd", 32'(rd_data), 32'h22);
    check("drain1_count", 32'(count), 3);
    step(0, 0, 1, 0);
    check("drain2_rd", 32'(rd_data), 32'h33);
    step(0, 0, 1, 0);
    check("drain3_rd", 32'(rd_data), 32'h44);
    check("drain3_aempty", 32'(almost_empty), 1);
    step(0, 0, 1, 0);
    check("drain4_empty", 32'(empty), 1);
    check("drain4_rd", 32'(rd_data), 0);
    check("drain4_ovf_sticky", 32'(overflow), 1);
    step(0, 0, 0, 1);
    check("clr_ovf", 32'(overflow), 0);

    // Simultaneous read/write at count=2
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    check("sim_pre_rd", 32'(rd_data), 32'hA0);
    step(1, 8'hA2, 1, 0);
    check("sim_count", 32'(count), 2);
    check("sim_rd", 32'(rd_data), 32'hA1);
    step(0, 0, 1, 0);
    check("sim_next_rd", 32'(rd_data), 32'hA2);
    step(0, 0, 1, 0);
    check("sim_empty", 32'(empty), 1);

    // Empty plus read & write
    step(1, 8'h7E, 1, 0);
    check("erw_count", 32'(count), 1);
    check("erw_rd", 32'(rd_data), 32'h7E);
    check("erw_unf", 32'(underflow), 1);
    check("erw_ovf", 32'(overflow), 0);
    step(0, 0, 0, 1);
    check("clr_unf", 32'(underflow), 0);
    step(0, 0, 1, 0);

    // Full plus read & write
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 0, 0);
    step(1, 8'h09, 1, 0);
    check("frw_count", 32'(count), 3);
    check("frw_ovf", 32'(overflow), 1);
    check("frw_rd", 32'(rd_data), 32'h02);

    // Asynchronous reset pulse between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_ovf", 32'(overflow), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1, 8'h66, 0, 0);
    check("arst_wr_rd", 32'(rd_data), 32'h66);
    check("arst_wr_count", 32'(count), 1);

    // Synchronous flush at count=2
    step(1, 8'h67, 0, 0);
    check("srst_pre_count", 32'(count), 2);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("srst_count", 32'(count), 0);
    check("srst_empty", 32'(empty), 1);
    step(1, 8'h5A, 0, 0);
    check("srst_wr_rd", 32'(rd_data), 32'h5A);
    check("srst_wr_count", 32'(count), 1);

    // Error set wins over simultaneous clear
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("unf_set", 32'(underflow), 1);
    step(0, 0, 1, 1);
    check("unf_set_wins", 32'(underflow), 1);
    step(0, 0, 0, 1);
    check("unf_cleared", 32'(underflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
